uart_tx_sched: RTL
==================

# uart_tx_sched

Round-robin scheduler sharing one `uart_tx` serializer among `N` byte producers: correlator readout, status reporter and command echo. It sits between the producers and the `uart_tx` instance, and runs on the same clock as the serializer. It grants one requester at a time, hands the byte to the serializer with a one-cycle `tx_start`, then tracks `tx_done` through the full frame before it re-arbitrates.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..8.
- `MAX_BURST`, 16: maximum consecutive bytes per grant (burst mode only), 1..255.
- `WD_CYCLES`, 4: cycles allowed for `tx_done` to fall after `tx_start`.

Ports:
- `clk`  in  1  clock; same clock that drives `uart_tx`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N  per-requester byte valid.
- `req_data`  in  8*N  byte of requester i on bits `[8i+7:8i]`.
- `req_ready`  out  N  one-cycle pulse: the byte of requester i was accepted.
- `grant`  out  N  one-hot index of the current or last owner; zero after reset.
- `tx_din`  out  8  byte to the serializer; held stable for the whole frame.
- `tx_start`  out  1  one-cycle start pulse to the serializer.
- `tx_done`  in  1  serializer idle flag.
- `busy`  out  1  high from grant until the frame completes.
- `err`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- States:
  - `IDLE`: arbitrate.
  - `START`: `tx_start` is high.
  - `WAIT_LOW`: wait for `tx_done` to fall.
  - `WAIT_HIGH`: wait for `tx_done` to rise.
- `IDLE`:
  - If `tx_done`=1 and any `req_valid` bit is set, pick a winner.
  - Search starts at the round-robin pointer `ptr` and wraps modulo N.
  - On the next edge the block registers `tx_din`, `grant` and `busy`=1, pulses `req_ready[winner]` and `tx_start`, and moves to `START`.
- `START` → `WAIT_LOW`. `tx_start` and `req_ready` drop.
- `WAIT_LOW`:
  - `tx_done`=0 → `WAIT_HIGH`. The serializer holds `tx_done` high for one cycle after the start, so that stale high is ignored.
  - If `tx_done` is still high after `WD_CYCLES` cycles: pulse `err`, go to `IDLE`, and treat the byte as consumed.
- `WAIT_HIGH`: `tx_done`=1 → `IDLE`, `busy`=0 on that edge.
- Pointer update: `ptr` becomes winner+1 (mod N) when the grant is released.
- Requester rules:
  - `req_data` must be stable while `req_valid` is high and no `req_ready` has been received.
  - A requester may drop `req_valid` without penalty while it is not granted.
  - Bytes accepted by `req_ready` are never dropped or duplicated.
- Simultaneous requests: only one `req_ready` bit is set per frame. Losers keep their data.

## Timing
- Reset values: `tx_start`=0, `tx_din`=0, `req_ready`=0, `grant`=0, `busy`=0, `err`=0, `ptr`=0, `burst_cnt`=0, state `IDLE`.
- Reset asserted mid-frame: everything returns to the reset values immediately. The serializer finishes its frame on its own; the block then waits for `tx_done`=1 in `IDLE`.
- Latency: `req_valid` is seen in cycle k (`IDLE`, `tx_done`=1) → `tx_start` and `req_ready` are high in cycle k+1.
- Back-to-back: the cycle `tx_done` returns high is `WAIT_HIGH`→`IDLE`, and the next `tx_start` follows one cycle later. Gap is 2 cycles of the serializer's idle state.
- All outputs are registered.

## Configuration
- `UART_TX_SCHED_BURST_EN` defined:
  - The current owner keeps the grant while its `req_valid` is seen high in `IDLE` and `burst_cnt` < `MAX_BURST`.
  - `burst_cnt` counts accepted bytes and clears on release.
  - `ptr` advances only on release: owner's `req_valid` low in `IDLE`, `MAX_BURST` reached, or watchdog.
  - This keeps packets contiguous on the line.
- Undefined: strict byte-level round robin. `ptr` advances after every byte and `burst_cnt` logic is absent.

## Test plan
- Single requester: N=4, `req_valid`=0001, `req_data[7:0]`=0x55, serializer model → one `tx_start` pulse, `tx_din`=0x55, one `req_ready`=0001, `busy` high until `tx_done` returns.
- Contention: `req_valid`=1111 held, bytes 0x10/0x21/0x32/0x43, burst macro off → grant order 0,1,2,3,0; no gaps beyond 2 cycles per frame.
- Burst: macro on, `MAX_BURST`=3, requesters 0 and 2 each stream 5 bytes → order 0,0,0,2,2,2,0,0,2,2.
- Watchdog: `tx_done` tied high after `tx_start` → `err` pulses after 4 `WAIT_LOW` cycles, return to `IDLE`, next requester served.
- Reset mid-frame: assert `rst_n`=0 during `WAIT_HIGH` → all outputs 0 within the same cycle; after release, no `tx_start` until `tx_done`=1.
- Valid withdrawal: requester 1 drops `req_valid` while requester 0 is granted → requester 1 gets no `req_ready` and no byte is sent for it.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one uart_tx serializer among N byte producers.
// Latency: a req_valid seen in IDLE with tx_done=1 gives tx_start and req_ready[winner] on the next cycle.
// Backpressure: a requester holds req_valid/req_data until its req_ready pulse; no grant while a frame is in flight.
// Optional feature macro: UART_TX_SCHED_BURST_EN (the owner keeps the grant for up to MAX_BURST bytes).
// Ports:
//   clk, rst_n            clock shared with uart_tx; asynchronous active-low reset
//   req_valid/req_data    per-requester byte offer (byte i on req_data[8i+7:8i])
//   req_ready             one-cycle accept pulse to the winning requester
//   grant                 one-hot current or last owner
//   tx_din/tx_start       byte and start pulse to the serializer; tx_din is held for the frame
//   tx_done               serializer idle flag
//   busy/err              frame in progress; one-cycle watchdog pulse
module uart_tx_sched #(
   parameter int N         = 4,
   parameter int MAX_BURST = 16,
   parameter int WD_CYCLES = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req_valid,
   input  logic [8*N-1:0] req_data,
   output logic [N-1:0]   req_ready,
   output logic [N-1:0]   grant,
   output logic [7:0]     tx_din,
   output logic           tx_start,
   input  logic           tx_done,
   output logic           busy,
   output logic           err
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int WW = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;

   if (N < 2 || N > 8) begin : g_bad_n
      $error("uart_tx_sched: N must be 2..8");
   end
   if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
      $error("uart_tx_sched: MAX_BURST must be 1..255");
   end
   if (WD_CYCLES < 1) begin : g_bad_wd
      $error("uart_tx_sched: WD_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_LOW  = 2'd2,
      WAIT_HIGH = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [WW-1:0]   wd_q, wd_d;
   logic [N-1:0]    req_ready_d, grant_d;
   logic [7:0]      tx_din_d;
   logic            tx_start_d, busy_d, err_d;

   // arbitration scratch
   logic [IW-1:0]   search, win, cand;
   logic            found;

`ifdef UART_TX_SCHED_BURST_EN
   logic [7:0]      burst_q, burst_d;
   logic            holding, keep;
`endif

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
      return (i == IW'(N - 1)) ? '0 : i + IW'(1);
   endfunction

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      wd_d        = wd_q;
      tx_din_d    = tx_din;
      grant_d     = grant;
      busy_d      = busy;
      tx_start_d  = 1'b0;
      req_ready_d = '0;
      err_d       = 1'b0;
      search      = ptr_q;
      found       = 1'b0;
      win         = '0;
      cand        = '0;
`ifdef UART_TX_SCHED_BURST_EN
      burst_d = burst_q;
      // burst_cnt is non-zero exactly while an owner holds the grant between frames
      holding = (burst_q != 8'd0);
      keep    = holding && req_valid[owner_q] && (burst_q < 8'(MAX_BURST));
`endif

      case (state_q)
         IDLE: begin
`ifdef UART_TX_SCHED_BURST_EN
            // release: the search restarts just past the old owner in the same cycle
            if (holding && !keep) begin
               burst_d = 8'd0;
               ptr_d   = next_idx(owner_q);
               search  = next_idx(owner_q);
            end
`endif
            for (int k = 0; k < N; k++) begin
               cand = IW'((int'(search) + k) % N);
               if (!found && req_valid[cand]) begin
                  found = 1'b1;
                  win   = cand;
               end
            end
`ifdef UART_TX_SCHED_BURST_EN
            if (keep) begin
               found = 1'b1;
               win   = owner_q;
            end
`endif
            if (tx_done && found) begin
               state_d          = START;
               owner_d          = win;
               grant_d          = N'(1) << win;
               req_ready_d      = N'(1) << win;
               tx_din_d         = req_data[8*int'(win) +: 8];
               tx_start_d       = 1'b1;
               busy_d           = 1'b1;
               wd_d             = '0;
`ifdef UART_TX_SCHED_BURST_EN
               burst_d = keep ? burst_q + 8'd1 : 8'd1;
`endif
            end
         end
         START: begin
            state_d = WAIT_LOW;
            wd_d    = '0;
         end
         WAIT_LOW: begin
            // tx_done is still high for a cycle after the start; only a fall counts
            if (!tx_done) begin
               state_d = WAIT_HIGH;
            end else if (wd_q == WW'(WD_CYCLES - 1)) begin
               // serializer never started: the byte is treated as consumed
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
               ptr_d   = next_idx(owner_q);
`ifdef UART_TX_SCHED_BURST_EN
               burst_d = 8'd0;
`endif
            end else begin
               wd_d = wd_q + WW'(1);
            end
         end
         WAIT_HIGH: begin
            if (tx_done) begin
               state_d = IDLE;
               busy_d  = 1'b0;
`ifndef UART_TX_SCHED_BURST_EN
               ptr_d   = next_idx(owner_q);
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         wd_q      <= '0;
         tx_din    <= 8'h00;
         grant     <= '0;
         req_ready <= '0;
         tx_start  <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         wd_q      <= wd_d;
         tx_din    <= tx_din_d;
         grant     <= grant_d;
         req_ready <= req_ready_d;
         tx_start  <= tx_start_d;
         busy      <= busy_d;
         err       <= err_d;
      end
   end

`ifdef UART_TX_SCHED_BURST_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_q <= 8'd0;
      end else begin
         burst_q <= burst_d;
      end
   end
`endif

endmodule
